// File: rtl/vga_sync_decoder_if.sv
// Pixel-clock-domain bundle between a VGA source (master) and the sync decoder (slave).
interface vga_sync_decoder_if;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       de;
  logic [2:0] red_out;
  logic [2:0] green_out;
  logic [2:0] blue_out;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [9:0] line_len;
  logic [9:0] frame_lines;

  modport master (
    output hsync, vsync, red, green, blue,
    input  xpos, ypos, de, red_out, green_out, blue_out,
           frame_start, locked, sync_err, line_len, frame_lines
  );

  modport slave (
    input  hsync, vsync, red, green, blue,
    output xpos, ypos, de, red_out, green_out, blue_out,
           frame_start, locked, sync_err, line_len, frame_lines
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery: coordinates, data-enable, line/frame
// measurement and lock detection against the configured video mode.
//
//   state  | meaning
//   SEARCH | no timing reference, waiting for a vsync falling edge
//   TRACK  | counting consecutive good frames toward lock
//   LOCKED | timing matches the mode, de is allowed out
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input logic               clk,
  input logic               reset_n,
  vga_sync_decoder_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] H_START   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [3:0] GOOD_LOCK = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic       hs_q, vs_q;
  logic [2:0] red_q, green_q, blue_q;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] lines_q, lines_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] frame_lines_q, frame_lines_d;
  logic       h_seen_q, h_seen_d;
  logic       line_bad_q, line_bad_d;

  state_t     state_q;
  logic [3:0] good_q;
  logic       locked_q;
  logic       sync_err_q;
  logic       frame_start_q;

  logic       de_q;
  logic [9:0] xpos_q, ypos_q;
  logic [2:0] red_out_q, green_out_q, blue_out_q;

  logic       h_fall, v_fall;
  logic [9:0] h_len;
  logic       bad_now;
  logic       frame_ok;
  logic       h_act, v_act, de_d;

  assign h_fall   = hs_q & ~bus.hsync;
  assign v_fall   = vs_q & ~bus.vsync;
  // Saturate so a runaway line reports 1023 rather than wrapping to 0.
  assign h_len    = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 10'd1;
  assign bad_now  = (h_cnt_q == CNT_MAX) | (h_fall & h_seen_q & (h_cnt_q != H_LAST));
  // A frame only counts if the line ending on this very edge is also clean.
  assign frame_ok = (lines_q == V_TOTAL_C) & ~line_bad_q & ~bad_now;

  assign h_act = (h_cnt_q >= H_START) && (h_cnt_q < H_END);
  assign v_act = (v_cnt_q >= V_START) && (v_cnt_q < V_END);
  assign de_d  = locked_q & h_act & v_act;

  // Sync edge history and the one-stage colour delay that aligns rgb with h_cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hs_q    <= bus.hsync;
      vs_q    <= bus.vsync;
      red_q   <= bus.red;
      green_q <= bus.green;
      blue_q  <= bus.blue;
    end
  end

  // Next-state for position counters and line/frame measurement.
  always_comb begin
    h_cnt_d = h_cnt_q;
    if (h_fall)                    h_cnt_d = '0;
    else if (h_cnt_q != CNT_MAX)   h_cnt_d = h_cnt_q + 10'd1;

    v_cnt_d = v_cnt_q;
    if (v_fall)                             v_cnt_d = '0;
    else if (h_fall && v_cnt_q != CNT_MAX)  v_cnt_d = v_cnt_q + 10'd1;

    // A coincident h_fall opens line 0 of the new frame, so it counts there.
    lines_d = lines_q;
    if (v_fall)                             lines_d = h_fall ? 10'd1 : 10'd0;
    else if (h_fall && lines_q != CNT_MAX)  lines_d = lines_q + 10'd1;

    frame_lines_d = v_fall ? lines_q : frame_lines_q;
    line_len_d    = (h_fall && h_seen_q) ? h_len : line_len_q;
    h_seen_d      = h_seen_q | h_fall;
    line_bad_d    = v_fall ? 1'b0 : (line_bad_q | bad_now);
  end

  // Counter and measurement registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      lines_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      h_seen_q      <= 1'b0;
      line_bad_q    <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      lines_q       <= lines_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      h_seen_q      <= h_seen_d;
      line_bad_q    <= line_bad_d;
    end
  end

  // Lock FSM with registered locked/sync_err/frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      sync_err_q    <= 1'b0;
      frame_start_q <= v_fall;
      case (state_q)
        SEARCH: begin
          if (v_fall) begin
            state_q <= TRACK;
            good_q  <= '0;
          end
        end
        TRACK: begin
          if (v_fall) begin
            if (frame_ok) begin
              good_q <= good_q + 4'd1;
              if ((good_q + 4'd1) == GOOD_LOCK) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (bad_now || (v_fall && lines_q != V_TOTAL_C)) begin
            state_q    <= SEARCH;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b1;
            good_q     <= '0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
          good_q   <= '0;
        end
      endcase
    end
  end

  // Registered output decode; everything blanks to 0 outside active video.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q        <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
      red_out_q   <= '0;
      green_out_q <= '0;
      blue_out_q  <= '0;
    end else begin
      de_q        <= de_d;
      xpos_q      <= de_d ? (h_cnt_q - H_START) : 10'd0;
      ypos_q      <= de_d ? (v_cnt_q - V_START) : 10'd0;
      red_out_q   <= de_d ? red_q   : 3'd0;
      green_out_q <= de_d ? green_q : 3'd0;
      blue_out_q  <= de_d ? blue_q  : 3'd0;
    end
  end

  assign bus.de          = de_q;
  assign bus.xpos        = xpos_q;
  assign bus.ypos        = ypos_q;
  assign bus.red_out     = red_out_q;
  assign bus.green_out   = green_out_q;
  assign bus.blue_out    = blue_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced video mode so that many
// frames fit in a short run: 16 clocks/line (sync 3, bp 3, active 8, fp 2) and
// 9 lines/frame (sync 2, bp 2, active 4, fp 1). Active region: h 6..13, v 4..7.
module tb_vga_sync_decoder;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = 16, VT = 9;
  localparam int GOTO_LIMIT = 5000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vga_sync_decoder_if vif();

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(vif)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Generator position of the next sample, and of the last sample clocked in.
  int gh, gv, gf, cur_len;
  int last_h, last_v, last_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic restart(input int f);
    gh = 0; gv = 0; gf = f; cur_len = HT;
    last_h = -1; last_v = -1; last_f = -1;
  endtask

  // Drive one sample, clock it in, then advance the generator.
  task automatic pix();
    vif.hsync = (gh < HS) ? 1'b0 : 1'b1;
    vif.vsync = (gv < VS) ? 1'b0 : 1'b1;
    vif.red   = 3'(gh);
    vif.green = 3'(gv);
    vif.blue  = 3'(gh + gv);
    @(posedge clk); #1;
    last_h = gh; last_v = gv; last_f = gf;
    if (gh == cur_len - 1) begin
      gh = 0;
      cur_len = HT;
      if (gv == VT - 1) begin gv = 0; gf++; end
      else gv++;
    end else begin
      gh++;
    end
  endtask

  task automatic goto(input int f, input int v, input int h);
    int n = 0;
    while (!(last_f == f && last_v == v && last_h == h) && n < GOTO_LIMIT) begin
      pix();
      n++;
    end
    if (n >= GOTO_LIMIT) begin
      n_total++;
      n_fail++;
      $error("FAIL goto: position f%0d v%0d h%0d not reached in %0d samples", f, v, h, n);
    end
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_de"},          32'(vif.de),          0);
    chk({pfx, "_xpos"},        32'(vif.xpos),        0);
    chk({pfx, "_ypos"},        32'(vif.ypos),        0);
    chk({pfx, "_red"},         32'(vif.red_out),     0);
    chk({pfx, "_green"},       32'(vif.green_out),   0);
    chk({pfx, "_blue"},        32'(vif.blue_out),    0);
    chk({pfx, "_frame_start"}, 32'(vif.frame_start), 0);
    chk({pfx, "_locked"},      32'(vif.locked),      0);
    chk({pfx, "_sync_err"},    32'(vif.sync_err),    0);
    chk({pfx, "_line_len"},    32'(vif.line_len),    0);
    chk({pfx, "_frame_lines"}, 32'(vif.frame_lines), 0);
  endtask

  initial begin
    int err_pulses;
    vif.hsync = 1'b1; vif.vsync = 1'b1;
    vif.red = '0; vif.green = '0; vif.blue = '0;
    restart(0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;

    // Nominal stream: v_fall #1 on the very first sample.
    goto(0, 0, 0);
    chk("fs_pulse", 32'(vif.frame_start), 1);
    chk("locked_f0", 32'(vif.locked), 0);
    pix();
    chk("fs_one_cycle", 32'(vif.frame_start), 0);

    goto(1, 0, 0);
    chk("locked_vfall2", 32'(vif.locked), 0);
    chk("frame_lines_f0", 32'(vif.frame_lines), VT);
    chk("line_len_f0", 32'(vif.line_len), HT);
    goto(1, 8, 15);
    chk("locked_pre_vfall3", 32'(vif.locked), 0);
    goto(2, 0, 0);
    chk("locked_vfall3", 32'(vif.locked), 1);
    chk("sync_err_lock", 32'(vif.sync_err), 0);
    chk("frame_lines_f1", 32'(vif.frame_lines), VT);

    // First active pixel (h=6, v=4) appears one edge after it is sampled.
    goto(2, 4, 6);
    chk("de_before_first", 32'(vif.de), 0);
    pix();
    chk("first_de", 32'(vif.de), 1);
    chk("first_x", 32'(vif.xpos), 0);
    chk("first_y", 32'(vif.ypos), 0);
    chk("first_red", 32'(vif.red_out), 6);
    chk("first_green", 32'(vif.green_out), 4);
    chk("first_blue", 32'(vif.blue_out), 2);

    // Last visible pixel (h=13, v=7) and the blanked one after it.
    goto(2, 7, 14);
    chk("last_de", 32'(vif.de), 1);
    chk("last_x", 32'(vif.xpos), HA - 1);
    chk("last_y", 32'(vif.ypos), VA - 1);
    pix();
    chk("after_last_de", 32'(vif.de), 0);
    chk("after_last_x", 32'(vif.xpos), 0);
    chk("after_last_y", 32'(vif.ypos), 0);

    // One short line (15 clocks) on line 2 of frame 3.
    goto(3, 1, 15);
    cur_len = HT - 1;
    goto(3, 2, 14);
    chk("locked_before_short", 32'(vif.locked), 1);
    goto(3, 3, 0);
    chk("short_sync_err", 32'(vif.sync_err), 1);
    chk("short_locked", 32'(vif.locked), 0);
    chk("short_line_len", 32'(vif.line_len), HT - 1);
    pix();
    chk("short_sync_err_once", 32'(vif.sync_err), 0);
    goto(4, 0, 0);
    chk("relock_vf1", 32'(vif.locked), 0);
    goto(5, 0, 0);
    chk("relock_vf2", 32'(vif.locked), 0);
    goto(6, 0, 0);
    chk("relock_vf3", 32'(vif.locked), 1);
    chk("coinc_v_cnt", 32'(dut.v_cnt_q), 0);
    chk("coinc_frame_lines", 32'(vif.frame_lines), VT);

    // hsync stuck high while locked.
    goto(6, 5, 3);
    chk("locked_before_hold", 32'(vif.locked), 1);
    err_pulses = 0;
    repeat (1100) begin
      vif.hsync = 1'b1;
      vif.vsync = 1'b1;
      @(posedge clk); #1;
      if (vif.sync_err === 1'b1) err_pulses++;
    end
    chk("hold_h_cnt_sat", 32'(dut.h_cnt_q), 1023);
    chk("hold_locked", 32'(vif.locked), 0);
    chk("hold_sync_err_pulses", 32'(err_pulses), 1);

    // Restart the stream and relock, then reset mid-frame.
    restart(10);
    goto(12, 0, 0);
    chk("relock_after_hold", 32'(vif.locked), 1);
    goto(12, 5, 9);
    chk("midframe_de", 32'(vif.de), 1);
    reset_n = 1'b0;
    #1;
    check_idle("midrst");
    chk("midrst_state", 32'(dut.state_q), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    restart(20);
    goto(20, 0, 0);
    chk("rst_relock_vf1", 32'(vif.locked), 0);
    goto(21, 8, 15);
    chk("rst_relock_vf2", 32'(vif.locked), 0);
    goto(22, 0, 0);
    chk("rst_relock_vf3", 32'(vif.locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. It samples hsync/vsync plus 3-bit RGB and recovers pixel coordinates and a data-enable. It also measures line and frame lengths and declares lock once the incoming timing matches the configured 640x480 mode. It sits on the pixel-clock domain and lets a bench or on-chip checker reconstruct what the game renders.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- LOCK_FRAMES, 2, consecutive good frames needed to lock
- H_TOTAL and V_TOTAL are derived as the sum of each group: 800 and 525.

Ports:
- clk  in  1  pixel clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- hsync, vsync  in  1 each  active-low sync pulses, same clock domain, no synchronizer
- red, green, blue  in  3 each  pixel colour
- xpos, ypos  out  10 each  recovered coordinates; 0 when de=0
- de  out  1  active-video pixel, qualified by locked
- red_out, green_out, blue_out  out  3 each  colour aligned with xpos/ypos/de
- frame_start  out  1  one-cycle pulse on a detected vsync falling edge
- locked  out  1  timing matches the parameters
- sync_err  out  1  one-cycle pulse when locked is lost
- line_len, frame_lines  out  10 each  last measured line length (clocks) and frame length (lines)

## Operation
- Edge detect:
  - hs_q/vs_q register the previous sample, reset to 1.
  - h_fall = hs_q & ~hsync.
  - v_fall = vs_q & ~vsync.
- h_cnt (10b):
  - Set to 0 on h_fall; otherwise increment, saturating at 1023.
  - The sample on the clock of h_fall has line offset 0.
- v_cnt (10b):
  - Set to 0 on v_fall, which wins over a simultaneous h_fall.
  - Otherwise increment on h_fall, saturating at 1023.
- Measurement:
  - On h_fall with h_seen=1, line_len <= h_cnt+1. h_seen sets on the first h_fall after reset.
  - lines counts h_fall events since the last v_fall.
  - On v_fall: frame_lines <= lines; lines <= 1 if h_fall is coincident, else 0.
- Line check:
  - A bad line is an h_fall with h_seen and h_cnt+1 != H_TOTAL, or h_cnt reaching 1023.
  - A bad line sets line_bad. line_bad clears on v_fall.
- FSM states and transitions:
  - SEARCH (reset state), on v_fall: go to TRACK, good=0.
  - TRACK, on v_fall:
    - If lines == V_TOTAL and !line_bad (and no bad line on this cycle): good+1.
    - Otherwise good=0.
    - When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED, on a bad line, or on v_fall with lines != V_TOTAL: go to SEARCH and pulse sync_err.
- Output decode (registered, from h_cnt/v_cnt/rgb_q):
  - de = locked & h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) & v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - xpos = h_cnt-(H_SYNC+H_BP) and ypos = v_cnt-(V_SYNC+V_BP) when de; otherwise 0.
  - Colour outputs are 0 when de=0.

## Timing
- Reset values of all outputs, counters, line_len, frame_lines, good and flags are 0. hs_q and vs_q reset to 1. The FSM resets to SEARCH.
- Reset is asynchronous. Asserting it mid-frame clears everything immediately, and lock reacquisition restarts from SEARCH.
- Latency:
  - rgb passes through one stage (rgb_q) and then the output register.
  - A sample taken at edge E+k (k lines-offset after h_fall at E) appears on xpos/de/colour outputs after edge E+k+1.
- frame_start and sync_err are high for exactly one cycle, the cycle after the detecting edge.
- locked rises and falls on the edge where the FSM transitions.
- Nominal stream starting at a frame boundary:
  - v_fall #1 enters TRACK.
  - #2 gives good=1.
  - #3 sets locked.
- All counter arithmetic is 10-bit unsigned. There is no wrap: counters saturate at 1023.

## Test plan
- Nominal 640x480 stream from reset, three or more frames:
  - locked=1 one cycle after the third v_fall.
  - line_len=800, frame_lines=525.
  - First de pixel: xpos=0, ypos=0, colour equal to the input from one sample earlier.
- Locked stream, last visible pixel:
  - xpos=639, ypos=479, de=1.
  - The next sample gives de=0, xpos=0.
- Locked stream with one 799-clock line:
  - sync_err pulses once, locked=0, line_len=799.
  - Relock occurs on the third good v_fall thereafter.
- hsync held high for 1100 clocks while locked:
  - h_cnt holds at 1023.
  - locked drops and sync_err pulses.
- reset_n asserted mid-frame while locked:
  - All outputs are 0 immediately and the FSM is in SEARCH.
  - After release, lock returns after three v_fall.
- Coincident h_fall and v_fall:
  - v_cnt=0 and that line counts toward the new frame.
  - frame_lines=525 each frame.
